// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } opc_class_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } alu_a_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_CMP   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

endpackage

// File: rtl/mc_opc_decode.sv
// Maps the 7-bit RV32I major opcode onto the controller's instruction class.
module mc_opc_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output opc_class_e opc_class
);

  always_comb begin
    unique case (opcode)
      OPC_OP:     opc_class = CLS_OP;
      OPC_OP_IMM: opc_class = CLS_OP_IMM;
      OPC_LUI:    opc_class = CLS_LUI;
      OPC_AUIPC:  opc_class = CLS_AUIPC;
      OPC_LOAD:   opc_class = CLS_LOAD;
      OPC_STORE:  opc_class = CLS_STORE;
      OPC_BRANCH: opc_class = CLS_BRANCH;
      OPC_JAL:    opc_class = CLS_JAL;
      OPC_JALR:   opc_class = CLS_JALR;
      default:    opc_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and retire count.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP instead of retiring as NOPs.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        illegal
);

  state_e      r_state;
  opc_class_e  r_cls;
  opc_class_e  w_cls;
  logic [31:0] r_instret;

  mc_opc_decode u_opc_decode (
    .opcode    (opcode),
    .opc_class (w_cls)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_ILLEGAL;
      r_instret <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls   <= w_cls;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (r_cls)
            CLS_LOAD, CLS_STORE: r_state <= S_MEM;
            CLS_BRANCH:          r_state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            CLS_ILLEGAL:         r_state <= S_TRAP;
`else
            CLS_ILLEGAL:         r_state <= S_FETCH;
`endif
            default:             r_state <= S_WB;
          endcase
        end
        S_MEM:    if (mem_ready) r_state <= (r_cls == CLS_STORE) ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP:   r_state <= S_TRAP;
`endif
        default:  r_state <= S_IDLE;
      endcase

      if (retire) r_instret <= r_instret + 32'd1;
    end
  end

  // Strobes decode from state + latched class; mem_ready only gates completion.
  // NOTE: every output gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        unique case (r_cls)
          CLS_OP: alu_op = ALU_FUNCT;
          CLS_OP_IMM: begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          CLS_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = 1'b1;
          end
          CLS_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = 1'b1;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_sel = 1'b1;
          CLS_BRANCH: begin
            alu_op = ALU_CMP;
            pc_we  = 1'b1;
            pc_src = br_taken ? PC_IMM : PC_PLUS4;
            retire = 1'b1;
          end
          CLS_ILLEGAL: begin
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
            pc_we  = 1'b1;
            retire = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (r_cls == CLS_STORE);
        if (mem_ready && r_cls == CLS_STORE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        unique case (r_cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_IMM;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign instret = r_instret;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule
